// File: rtl/bram_weights_pkg.sv
// Shared types and elaboration-time helpers for the ping-pong weights buffer.
`timescale 1ns/1ps
package bram_weights_pkg;

   // Ownership state of one weights bank.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } bank_state_t;

   // True when the wide read word is a whole number of write beats.
   function automatic bit width_ratio_ok(input int r_width, input int w_width);
      return (w_width > 0) && (r_width >= w_width) && ((r_width % w_width) == 0);
   endfunction

   // Lane counter width; at least one bit so RATIO==1 still has a legal vector.
   function automatic int lane_width(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/bram_weights_pingpong_if.sv
// Write-stream and read-port bundle of the ping-pong weights buffer.
// master: the DMA/PE side driving beats and reads; slave: the buffer itself.
`timescale 1ns/1ps
interface bram_weights_pingpong_if #(
   parameter int W_DATA_WIDTH = 8,
   parameter int R_DATA_WIDTH = 32,
   parameter int R_ADDR_WIDTH = 3
);
   logic                    s_valid;
   logic                    s_ready;
   logic [W_DATA_WIDTH-1:0] s_data;
   logic                    s_last;
   logic                    r_en;
   logic [R_ADDR_WIDTH-1:0] r_addr;
   logic [R_DATA_WIDTH-1:0] r_data;
   logic                    r_valid;
   logic                    r_bank_ready;
   logic                    r_release;

   modport master (
      output s_valid, s_data, s_last, r_en, r_addr, r_release,
      input  s_ready, r_data, r_valid, r_bank_ready
   );

   modport slave (
      input  s_valid, s_data, s_last, r_en, r_addr, r_release,
      output s_ready, r_data, r_valid, r_bank_ready
   );
endinterface

// File: rtl/bram_weights_bank.sv
// One weights bank: simple dual-port RAM, synchronous write and read.
// Kept minimal so it can be replaced by a vendor/ASIC memory macro.
`timescale 1ns/1ps
module bram_weights_bank #(
   parameter int R_DEPTH      = 8,
   parameter int R_DATA_WIDTH = 32,
   parameter int R_ADDR_WIDTH = $clog2(R_DEPTH)
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [R_ADDR_WIDTH-1:0] waddr,
   input  logic [R_DATA_WIDTH-1:0] wdata,
   input  logic                    re,
   input  logic [R_ADDR_WIDTH-1:0] raddr,
   output logic [R_DATA_WIDTH-1:0] rdata
);
   logic [R_DATA_WIDTH-1:0] mem [R_DEPTH];

   // Write port and registered read port; read data holds when re is low.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/bram_weights_pingpong.sv
// Ping-pong weights buffer: narrow beats are packed into wide words and filled
// into the EMPTY bank while the PE array reads the FULL bank.
// Optional macro BRAM_WEIGHTS_PINGPONG_OREG_EN adds an output register
// (read latency 2 instead of 1).
`timescale 1ns/1ps
module bram_weights_pingpong
   import bram_weights_pkg::*;
#(
   parameter int R_DEPTH      = 8,
   parameter int R_DATA_WIDTH = 32,
   parameter int W_DATA_WIDTH = 8
) (
   input logic clk,
   input logic rst,
   bram_weights_pingpong_if.slave bus
);
   localparam int RATIO        = R_DATA_WIDTH / W_DATA_WIDTH;
   localparam int R_ADDR_WIDTH = $clog2(R_DEPTH);
   localparam int LANE_WIDTH   = lane_width(RATIO);

   if (!width_ratio_ok(R_DATA_WIDTH, W_DATA_WIDTH)) begin : g_bad_ratio
      $fatal(1, "R_DATA_WIDTH must be an integer multiple of W_DATA_WIDTH");
   end

   bank_state_t             bank_state_q [2];
   bank_state_t             bank_state_d [2];
   logic                    wr_bank_q;
   logic                    rd_bank_q;
   logic                    r_bank_ready_q;
   logic [LANE_WIDTH-1:0]   lane_q;
   logic [R_ADDR_WIDTH-1:0] waddr_q;
   logic [R_DATA_WIDTH-1:0] pack_q;
   logic [R_DATA_WIDTH-1:0] pack_word;
   logic                    beat_acc;
   logic                    word_done;
   logic                    fill_done;
   logic                    rd_acc;
   logic                    rel_acc;
   logic [R_DATA_WIDTH-1:0] bank_rdata [2];
   logic                    vld_p1;
   logic                    sel_p1;
   logic                    seen_p1;
   logic [R_DATA_WIDTH-1:0] rdata_p1;

   assign bus.s_ready  = ~rst & (bank_state_q[wr_bank_q] == EMPTY);
   assign beat_acc     = bus.s_valid & bus.s_ready;
   assign word_done    = beat_acc & (bus.s_last | (lane_q == LANE_WIDTH'(RATIO - 1)));
   assign fill_done    = word_done & (bus.s_last | (waddr_q == R_ADDR_WIDTH'(R_DEPTH - 1)));
   assign rd_acc       = bus.r_en & r_bank_ready_q;
   assign rel_acc      = bus.r_release & r_bank_ready_q;
   assign bus.r_bank_ready = r_bank_ready_q;

   // Merge the incoming beat into its lane; lanes above it are still zero.
   always_comb begin
      pack_word = pack_q;
      pack_word[int'(lane_q) * W_DATA_WIDTH +: W_DATA_WIDTH] = bus.s_data;
   end

   // Packer: lane/word counters, pending partial word, and fill-bank pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q    <= '0;
         waddr_q   <= '0;
         pack_q    <= '0;
         wr_bank_q <= 1'b0;
      end else if (beat_acc) begin
         if (word_done) begin
            lane_q  <= '0;
            pack_q  <= '0;
            waddr_q <= fill_done ? '0 : waddr_q + 1'b1;
            if (fill_done) wr_bank_q <= ~wr_bank_q;
         end else begin
            lane_q <= lane_q + 1'b1;
            pack_q <= pack_word;
         end
      end
   end

   // Bank ownership next state: fill closes the write bank, release frees the read bank.
   always_comb begin
      bank_state_d = bank_state_q;
      if (fill_done) bank_state_d[wr_bank_q] = FULL;
      if (rel_acc)   bank_state_d[rd_bank_q] = EMPTY;
   end

   // Bank state register, read-bank pointer and registered bank-ready flag.
   // On a release the flag follows the bank being handed over, so it never
   // reports a freed bank as readable.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_state_q[0] <= EMPTY;
         bank_state_q[1] <= EMPTY;
         rd_bank_q       <= 1'b0;
         r_bank_ready_q  <= 1'b0;
      end else begin
         bank_state_q   <= bank_state_d;
         if (rel_acc) rd_bank_q <= ~rd_bank_q;
         r_bank_ready_q <= rel_acc ? (bank_state_q[~rd_bank_q] == FULL)
                                   : (bank_state_q[rd_bank_q] == FULL);
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_bank
      bram_weights_bank #(
         .R_DEPTH      (R_DEPTH),
         .R_DATA_WIDTH (R_DATA_WIDTH),
         .R_ADDR_WIDTH (R_ADDR_WIDTH)
      ) u_bank (
         .clk   (clk),
         .we    (word_done & (wr_bank_q == 1'(i))),
         .waddr (waddr_q),
         .wdata (pack_word),
         .re    (rd_acc & (rd_bank_q == 1'(i))),
         .raddr (bus.r_addr),
         .rdata (bank_rdata[i])
      );
   end

   // ---- stage p1: RAM output; remember which bank answered the last read ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         sel_p1  <= 1'b0;
         seen_p1 <= 1'b0;
      end else begin
         vld_p1 <= rd_acc;
         if (rd_acc) begin
            sel_p1  <= rd_bank_q;
            seen_p1 <= 1'b1;
         end
      end
   end

   // Until the first read after reset the RAM output is undefined; present zero.
   assign rdata_p1 = seen_p1 ? bank_rdata[sel_p1] : '0;

`ifdef BRAM_WEIGHTS_PINGPONG_OREG_EN
   logic                    vld_p2;
   logic [R_DATA_WIDTH-1:0] rdata_p2;

   // ---- stage p2: extra output register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2   <= 1'b0;
         rdata_p2 <= '0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) rdata_p2 <= rdata_p1;
      end
   end

   assign bus.r_data  = rdata_p2;
   assign bus.r_valid = vld_p2;
`else
   assign bus.r_data  = rdata_p1;
   assign bus.r_valid = vld_p1;
`endif
endmodule

// File: tb/tb_bram_weights_pingpong.sv
// Directed bench for bram_weights_pingpong with a read-data scoreboard.
`timescale 1ns/1ps
module tb_bram_weights_pingpong;
   localparam int R_DEPTH      = 8;
   localparam int R_DATA_WIDTH = 32;
   localparam int W_DATA_WIDTH = 8;
   localparam int R_ADDR_WIDTH = 3;
`ifdef BRAM_WEIGHTS_PINGPONG_OREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bram_weights_pingpong_if #(
      .W_DATA_WIDTH (W_DATA_WIDTH),
      .R_DATA_WIDTH (R_DATA_WIDTH),
      .R_ADDR_WIDTH (R_ADDR_WIDTH)
   ) bus ();

   bram_weights_pingpong #(
      .R_DEPTH      (R_DEPTH),
      .R_DATA_WIDTH (R_DATA_WIDTH),
      .W_DATA_WIDTH (W_DATA_WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model [2][8];
   int          wr_m = 0;
   int          rd_m = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every r_valid pulse must match the oldest pending read.
   always @(negedge clk) begin
      if (!rst && bus.r_valid) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL r_valid_spurious: observed r_data=%h expected no read", bus.r_data);
         end
         if (exp_q.size() != 0) check("r_data", bus.r_data, exp_q.pop_front());
      end
   end

   task automatic wait_sready();
      int n = 0;
      if (!bus.s_ready) begin
         bus.s_valid = 1'b0;
         bus.r_en    = 1'b0;
         while (!bus.s_ready && n < 50) begin
            tick();
            n++;
         end
         check("s_ready_wait", bus.s_ready, 1);
      end
   endtask

   task automatic wait_bank_ready();
      int n = 0;
      while (!bus.r_bank_ready && n < 50) begin
         tick();
         n++;
      end
      check("r_bank_ready_wait", bus.r_bank_ready, 1);
   endtask

   // Stream n beats start, start+1, ...; optionally issue a read every beat.
   task automatic fill(input int n, input logic [7:0] start, input bit with_last, input bit rd_each);
      int          lane = 0;
      int          addr = 0;
      logic [31:0] word = '0;
      logic [7:0]  d;
      bit          last;
      for (int i = 0; i < n; i++) begin
         wait_sready();
         d    = start + 8'(i);
         last = with_last && (i == n - 1);
         bus.s_valid = 1'b1;
         bus.s_data  = d;
         bus.s_last  = last;
         if (rd_each) begin
            bus.r_en   = 1'b1;
            bus.r_addr = 3'(i % 8);
            exp_q.push_back(model[rd_m][i % 8]);
         end
         tick();
         word[lane*8 +: 8] = d;
         if (lane == 3 || last) begin
            model[wr_m][addr] = word;
            word = '0;
            lane = 0;
            if (last || addr == 7) begin
               wr_m ^= 1;
               addr = 0;
            end else addr++;
         end else lane++;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.r_en    = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] addr, input logic [31:0] exp);
      bus.r_en   = 1'b1;
      bus.r_addr = addr;
      exp_q.push_back(exp);
      tick();
      bus.r_en = 1'b0;
      repeat (LAT - 1) tick();
      check("r_valid_latency", bus.r_valid, 1);
      tick();
      check("r_valid_pulse", bus.r_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200us");
      $fatal(1, "timeout");
   end

   initial begin
      bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
      bus.r_en = 1'b0; bus.r_addr = '0; bus.r_release = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_r_valid", bus.r_valid, 0);
      check("rst_r_bank_ready", bus.r_bank_ready, 0);
      check("rst_r_data", bus.r_data, 0);
      rst = 1'b0;
      tick();
      check("post_rst_s_ready", bus.s_ready, 1);

      // Read while no bank ready is ignored
      bus.r_en = 1'b1; bus.r_addr = 3'd1;
      tick();
      bus.r_en = 1'b0;
      repeat (LAT) tick();
      check("ignored_read_valid", bus.r_valid, 0);
      check("ignored_read_data", bus.r_data, 0);

      // Full 32-beat fill of bank0
      fill(32, 8'h00, 1'b1, 1'b0);
      check("rbr_lag", bus.r_bank_ready, 0);
      check("s_ready_bank1_free", bus.s_ready, 1);
      tick();
      check("rbr_after_fill", bus.r_bank_ready, 1);
      do_read(3'd0, 32'h03020100);
      do_read(3'd7, 32'h1F1E1D1C);

      // Fill bank1 while reading bank0 every cycle
      fill(32, 8'h40, 1'b1, 1'b1);
      tick();
      check("s_ready_both_full", bus.s_ready, 0);
      check("rbr_bank0_held", bus.r_bank_ready, 1);
      bus.r_release = 1'b1;
      tick();
      bus.r_release = 1'b0;
      rd_m ^= 1;
      check("rbr_after_release", bus.r_bank_ready, 1);
      check("s_ready_after_release", bus.s_ready, 1);
      do_read(3'd0, 32'h43424140);
      do_read(3'd7, 32'h5F5E5D5C);

      // Partial fill of bank0: 6 beats
      fill(6, 8'hA1, 1'b1, 1'b0);
      tick();
      check("s_ready_partial_full", bus.s_ready, 0);

      // Read and release together: read hits old bank1 word 2
      bus.r_en = 1'b1; bus.r_addr = 3'd2; bus.r_release = 1'b1;
      exp_q.push_back(32'h4B4A4948);
      tick();
      bus.r_en = 1'b0; bus.r_release = 1'b0;
      rd_m ^= 1;
      check("rbr_other_full", bus.r_bank_ready, 1);
      repeat (LAT) tick();
      do_read(3'd0, 32'hA4A3A2A1);
      do_read(3'd1, 32'h0000A6A5);
      check("model_partial_w1", model[0][1], 32'h0000A6A5);

      // Release with other bank empty: ready drops, reads ignored
      bus.r_release = 1'b1;
      tick();
      bus.r_release = 1'b0;
      rd_m ^= 1;
      check("rbr_drop", bus.r_bank_ready, 0);
      bus.r_en = 1'b1; bus.r_addr = 3'd0;
      tick();
      bus.r_en = 1'b0;
      repeat (LAT) tick();
      check("ignored_read2_valid", bus.r_valid, 0);

      // 32 beats without s_last: bank closes at the last address
      fill(32, 8'h60, 1'b0, 1'b0);
      wait_bank_ready();
      check("s_ready_after_addr_close", bus.s_ready, 1);
      do_read(3'd7, 32'h7F7E7D7C);
      do_read(3'd3, model[rd_m][3]);

      // Reset in the middle of a fill
      fill(10, 8'h80, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      check("midrst_s_ready", bus.s_ready, 0);
      check("midrst_r_bank_ready", bus.r_bank_ready, 0);
      check("midrst_r_valid", bus.r_valid, 0);
      check("midrst_r_data", bus.r_data, 0);
      rst = 1'b0;
      wr_m = 0; rd_m = 0;
      tick();
      check("midrst_s_ready_back", bus.s_ready, 1);
      check("midrst_rbr_low", bus.r_bank_ready, 0);
      fill(32, 8'hC0, 1'b1, 1'b0);
      wait_bank_ready();
      do_read(3'd0, 32'hC3C2C1C0);
      do_read(3'd2, 32'hCBCAC9C8);

      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
